// File: rtl/floating_point_divider_sequential.sv
// Multi-cycle IEEE-754 binary32 divider: radix-2 restoring mantissa division,
// one quotient bit per clock, truncated result with fixed 26-cycle latency.
module floating_point_divider_sequential (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, DIVIDE = 2'd1, PACK = 2'd2} state_t;

  state_t      state;
  state_t      state_next;
  logic [4:0]  iter;
  logic [31:0] a_r;
  logic [31:0] b_r;
  logic [24:0] rem;
  logic [24:0] q;

  // Restoring step: compare, conditionally subtract, shift.
  logic [23:0] mb;
  logic        rem_ge;
  logic [24:0] rem_sub;
  logic [24:0] rem_next;

  assign mb       = {1'b1, b_r[22:0]};
  assign rem_ge   = rem >= {1'b0, mb};
  assign rem_sub  = rem_ge ? (rem - {1'b0, mb}) : rem;
  assign rem_next = {rem_sub[23:0], 1'b0};

  // Field decode and special-case classification of the captured operands.
  logic       sign;
  logic [7:0] ea;
  logic [7:0] eb;
  logic       a_zero, a_inf, a_nan;
  logic       b_zero, b_inf, b_nan;

  assign sign   = a_r[31] ^ b_r[31];
  assign ea     = a_r[30:23];
  assign eb     = b_r[30:23];
  assign a_zero = (ea == 8'h00);
  assign b_zero = (eb == 8'h00);
  assign a_inf  = (ea == 8'hFF) && (a_r[22:0] == 23'h0);
  assign b_inf  = (eb == 8'hFF) && (b_r[22:0] == 23'h0);
  assign a_nan  = (ea == 8'hFF) && (a_r[22:0] != 23'h0);
  assign b_nan  = (eb == 8'hFF) && (b_r[22:0] != 23'h0);

  logic [22:0] frac;
  logic [9:0]  exp_calc;
  logic [31:0] pack_result;
  logic        pack_ov;
  logic        pack_uf;
  logic        pack_dz;

  assign frac     = q[24] ? q[23:1] : q[22:0];
  // Quotient in [0.5,2): a leading zero costs one from the exponent.
  assign exp_calc = {2'b00, ea} - {2'b00, eb} + 10'd127 - {9'd0, ~q[24]};

  always_comb begin
    pack_result = {sign, exp_calc[7:0], frac};
    pack_ov     = 1'b0;
    pack_uf     = 1'b0;
    pack_dz     = 1'b0;
    if (a_nan || b_nan || (a_inf && b_inf) || (a_zero && b_zero)) begin
      pack_result = 32'h7FC00000;
    end else if (b_zero) begin
      pack_result = {sign, 8'hFF, 23'h0};
      pack_dz     = 1'b1;
    end else if (a_inf) begin
      pack_result = {sign, 8'hFF, 23'h0};
    end else if (b_inf || a_zero) begin
      pack_result = {sign, 31'h0};
    end else if ($signed(exp_calc) >= 10'sd255) begin
      pack_result = {sign, 8'hFF, 23'h0};
      pack_ov     = 1'b1;
    end else if ($signed(exp_calc) <= 10'sd0) begin
      pack_result = {sign, 31'h0};
      pack_uf     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = DIVIDE;
      DIVIDE:  if (iter == 5'd24) state_next = PACK;
      PACK:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_r         <= 32'h0;
      b_r         <= 32'h0;
      iter        <= 5'd0;
      rem         <= 25'h0;
      q           <= 25'h0;
      done        <= 1'b0;
      result      <= 32'h0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_r  <= a;
            b_r  <= b;
            iter <= 5'd0;
            rem  <= {2'b01, a[22:0]};
            q    <= 25'h0;
          end
        end
        DIVIDE: begin
          rem  <= rem_next;
          q    <= {q[23:0], rem_ge};
          iter <= iter + 5'd1;
        end
        PACK: begin
          result      <= pack_result;
          overflow    <= pack_ov;
          underflow   <= pack_uf;
          div_by_zero <= pack_dz;
          done        <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign dbg_state = state;

endmodule

// File: doc/floating_point_divider_sequential.md
# floating_point_divider_sequential

Multi-cycle IEEE-754 single-precision divider. It is the inverse-operation companion to the sequential floating-point multiplier in the arithmetic datapath. It accepts an operand pair on a start pulse and computes a/b with a radix-2 restoring mantissa divider, one quotient bit per clock. It returns a registered result with a one-cycle done pulse after a fixed latency. Operands and results use the same 32-bit packing and overflow convention as the multiplier.

## Interface
- No parameters; format fixed at binary32 (1 sign, 8 exponent bias 127, 23 fraction).
- clk  input  1  single clock, rising-edge.
- rst  input  1  asynchronous, active-low reset.
- a  input  32  dividend; sampled only on the accepting edge.
- b  input  32  divisor; sampled only on the accepting edge.
- start  input  1  request; accepted when high on an edge in IDLE.
- busy  output  1  high from the accepting edge until done is asserted; reset 0.
- done  output  1  one-cycle pulse when result/flags are valid; reset 0.
- result  output  32  quotient; held until the next done; reset 32'h0.
- overflow  output  1  exponent overflow (result forced ±inf); reset 0.
- underflow  output  1  exponent underflow (result forced ±0); reset 0.
- div_by_zero  output  1  finite or inf nonzero a divided by zero b; reset 0.

## Operation
- States: IDLE, DIVIDE, PACK.
  - IDLE → DIVIDE on start=1. This edge captures a and b, and clears the iteration counter.
  - DIVIDE runs 25 iterations, then goes to PACK.
  - PACK → IDLE. This edge registers result and flags, and drives done=1 for the following cycle.
- start while busy is ignored and has no effect on the operation in flight.
- Unpack: exponent field 0 means zero; denormal inputs flush to zero. Mantissas are ma={1,frac_a} and mb={1,frac_b}, 24 bits each.
- Sign is sign_a XOR sign_b for every result, including zero and inf.
- Iteration i=0..24 (remainder 25 bits, initial value ma):
  - if rem ≥ mb: q[24−i]=1 and rem=rem−mb;
  - then rem=rem<<1.
- Normalize:
  - if q[24]=1: frac=q[23:1], adj=0;
  - else: frac=q[22:0], adj=−1.
  - Truncate; no rounding. Remainder bits are discarded.
- Exponent: e = ea − eb + 127 + adj, computed in 10-bit signed arithmetic.
  - e ≥ 255: result = {s, 8'hFF, 23'h0}, overflow=1.
  - e ≤ 0: result = {s, 31'h0}, underflow=1.
- Special cases are resolved in PACK with the same fixed latency. Priority order:
  1. Either input is NaN, or inf/inf, or 0/0 → 32'h7FC00000, all flags 0.
  2. b is zero (a nonzero) → ±inf, div_by_zero=1.
  3. a is inf → ±inf.
  4. b is inf or a is zero → ±0.
- Flags and result from a completed operation hold until the next PACK overwrites them.
- Reset asserted at any time, including mid-DIVIDE, immediately forces:
  - state IDLE;
  - busy=0, done=0;
  - result=0 and all flags 0.
  - The operation in flight is abandoned.

## Timing
- Accepting edge T: busy=1 from T.
- Iterations occur on edges T+1..T+25; PACK is edge T+26.
- At edge T+26: done=1, busy=0, result valid.
- At edge T+27: done=0.
- Total latency is 26 cycles from accept to done, fixed for all operand values and special cases.
- Back-to-back: start high during the done cycle (IDLE) is accepted at edge T+27. Maximum throughput is one operation per 27 cycles.
- result and flags only change on the PACK edge or on reset.

## Test plan
- a=0x40C00000 (6.0), b=0x40000000 (2.0), start 1 cycle → done at +26, result=0x40400000, all flags 0, busy low with done.
- a=0x3F800000 (1.0), b=0x40400000 (3.0) → result=0x3EAAAAAA (truncated); a=0xC0C00000 (−6.0), b=0x40000000 → result=0xC0400000.
- Specials:
  - a=0x3F800000, b=0x00000000 → 0x7F800000 with div_by_zero=1;
  - 0/0 → 0x7FC00000;
  - a=0x7F800000, b=0x7F800000 → 0x7FC00000;
  - a=0x3F800000, b=0xFF800000 → 0x80000000;
  - each with done exactly at +26.
- Range limits:
  - a=0x7F000000, b=0x3E800000 → 0x7F800000 with overflow=1;
  - a=0x00800000, b=0x40000000 → 0x00000000 with underflow=1.
- Control:
  - start re-pulsed at +5 with different operands → ignored; first result returned at +26.
  - start held high through done → second op accepted at +27, done at +53.
- Reset:
  - rst low at +12 → busy=0, done=0, result=0, flags=0 immediately (asynchronous).
  - After release, a new 6.0/2.0 op completes correctly in 26 cycles with no stale done pulse.
